// File: rtl/sram_client_pkg.sv
// Shared definitions for the SRAM client interface.
// The client queue and the downstream SRAM state machine both import this package.
package sram_client_pkg;

    localparam int unsigned CMD_W    = 4;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned NUM_CMDS = 4;

    typedef enum logic [CMD_W-1:0] {
        PowerOff = 4'd0,
        PowerOn  = 4'd1,
        Read     = 4'd2,
        Write    = 4'd3
    } sram_cmd_t;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] data;
    } client_req_t;

    // Command codes 0..num_cmds-1 are the only ones the state machine understands.
    function automatic logic cmd_is_legal(input logic [31:0] cmd, input int unsigned num_cmds);
        return cmd < num_cmds;
    endfunction

endpackage

// File: rtl/sram_client_queue_mem.sv
// Storage array for sram_client_queue: one synchronous write port and one
// asynchronous read port. Contents are not reset; validity is tracked by the
// queue's occupancy counter.
module sram_client_queue_mem #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 20
) (
    input  logic                     clk_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(Depth)-1:0] wr_addr_i,
    input  logic [Width-1:0]         wr_data_i,
    input  logic [$clog2(Depth)-1:0] rd_addr_i,
    output logic [Width-1:0]         rd_data_o
);

    logic [Width-1:0] mem_q [Depth];

    // Write the addressed entry on an accepted legal push.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sram_client_queue.sv
// Client-side request buffer in front of the SRAM state machine.
// Captures {command, data} pairs, drops illegal command codes (flagging them on
// the sticky illegal_cmd output) and presents entries in FIFO order over a
// valid/ready handshake.
// Optional build macro: SRAM_CLIENT_QUEUE_BYPASS_EN -- when defined, a legal entry
// arriving at an empty queue is presented in the same cycle and, if consumed
// immediately, never written to storage.
module sram_client_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CMD_WIDTH  = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_CMDS   = sram_client_pkg::NUM_CMDS
) (
    input  logic                         CLK,
    input  logic                         ASYNCRESET,
    input  logic [CMD_WIDTH-1:0]         client_cmd,
    input  logic [DATA_WIDTH-1:0]        client_data,
    input  logic                         client_valid,
    output logic                         client_ready,
    output logic [CMD_WIDTH-1:0]         offer,
    output logic [DATA_WIDTH-1:0]        receive,
    output logic                         dfcq_valid,
    input  logic                         dfcq_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         illegal_cmd,
    input  logic                         clear_err
);

    import sram_client_pkg::*;

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned OccW   = $clog2(DEPTH + 1);
    localparam int unsigned EntryW = CMD_WIDTH + DATA_WIDTH;

    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OccW-1:0]   occ_q, occ_d;
    logic              err_q, err_d;

    logic              push;
    logic              cmd_legal;
    logic              store_wr;
    logic              store_rd;
    logic              stored_valid;
    logic [EntryW-1:0] head_entry;
    logic [EntryW-1:0] out_entry;

    // Ready depends only on registered occupancy and reset, never on dfcq_ready.
    assign client_ready = (occ_q != OccW'(DEPTH)) && !ASYNCRESET;
    assign push         = client_valid && client_ready;
    assign cmd_legal    = cmd_is_legal(32'(client_cmd), NUM_CMDS);
    assign stored_valid = (occ_q != '0);

`ifdef SRAM_CLIENT_QUEUE_BYPASS_EN
    logic bypass;

    // An empty queue forwards a legal entry straight through; illegal ones never bypass.
    assign bypass     = !stored_valid && push && cmd_legal;
    assign dfcq_valid = stored_valid || bypass;
    assign out_entry  = bypass ? {client_cmd, client_data} : head_entry;
    // Skip the write when the bypassed entry is consumed in the same cycle.
    assign store_wr   = push && cmd_legal && !(bypass && dfcq_ready);
`else
    assign dfcq_valid = stored_valid;
    assign out_entry  = head_entry;
    assign store_wr   = push && cmd_legal;
`endif

    // Only entries actually held in storage advance the read pointer.
    assign store_rd = dfcq_valid && dfcq_ready && stored_valid;

    assign {offer, receive} = dfcq_valid ? out_entry : '0;
    assign occupancy        = occ_q;
    assign illegal_cmd      = err_q;

    sram_client_queue_mem #(
        .Depth (DEPTH),
        .Width (EntryW)
    ) u_mem (
        .clk_i     (CLK),
        .wr_en_i   (store_wr),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i ({client_cmd, client_data}),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (head_entry)
    );

    // Next-state for pointers, occupancy and the sticky error flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        err_d    = err_q;
        if (store_wr) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (store_rd) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        occ_d = occ_q + OccW'(store_wr) - OccW'(store_rd);
        // A new illegal push wins over a simultaneous clear.
        if (push && !cmd_legal) begin
            err_d = 1'b1;
        end else if (clear_err) begin
            err_d = 1'b0;
        end
    end

    // State registers; reset drops all queued entries at once.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_sram_client_queue.sv
// Self-checking bench for sram_client_queue: a directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a queue-based reference model.
module tb_sram_client_queue;

    import sram_client_pkg::*;

    localparam int unsigned DEPTH = 4;
`ifdef SRAM_CLIENT_QUEUE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic        real_clk = 1'b0;
    logic        ASYNCRESET;
    logic [3:0]  client_cmd;
    logic [15:0] client_data;
    logic        client_valid;
    logic        client_ready;
    logic [3:0]  offer;
    logic [15:0] receive;
    logic        dfcq_valid;
    logic        dfcq_ready;
    logic [2:0]  occupancy;
    logic        illegal_cmd;
    logic        clear_err;

    int n_tests = 0;
    int n_fail  = 0;

    client_req_t mq[$];
    bit          m_err = 1'b0;

    typedef struct packed {
        logic        valid;
        logic [3:0]  cmd;
        logic [15:0] data;
        logic        ready;
        logic        clr;
        logic        exp_valid;
        logic [3:0]  exp_offer;
        logic [15:0] exp_recv;
        logic [2:0]  exp_occ;
        logic        exp_cready;
        logic        exp_ill;
    } vec_t;

    vec_t vq[$];

    always #5 real_clk = ~real_clk;

    sram_client_queue #(
        .DEPTH      (DEPTH),
        .CMD_WIDTH  (4),
        .DATA_WIDTH (16),
        .NUM_CMDS   (NUM_CMDS)
    ) dut (
        .CLK          (real_clk),
        .ASYNCRESET   (ASYNCRESET),
        .client_cmd   (client_cmd),
        .client_data  (client_data),
        .client_valid (client_valid),
        .client_ready (client_ready),
        .offer        (offer),
        .receive      (receive),
        .dfcq_valid   (dfcq_valid),
        .dfcq_ready   (dfcq_ready),
        .occupancy    (occupancy),
        .illegal_cmd  (illegal_cmd),
        .clear_err    (clear_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [3:0] c, input logic [15:0] d,
                       input logic r, input logic clr, input logic ev, input logic [3:0] eo,
                       input logic [15:0] ed, input logic [2:0] eocc, input logic ecr,
                       input logic eill);
        vec_t x;
        x = '{valid: v, cmd: c, data: d, ready: r, clr: clr, exp_valid: ev, exp_offer: eo,
              exp_recv: ed, exp_occ: eocc, exp_cready: ecr, exp_ill: eill};
        vq.push_back(x);
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [15:0] d,
                         input logic r, input logic clr);
        client_valid = v;
        client_cmd   = c;
        client_data  = d;
        dfcq_ready   = r;
        clear_err    = clr;
    endtask

    // One clock cycle checked against the reference queue model.
    task automatic step(input logic v, input logic [3:0] c, input logic [15:0] d,
                        input logic r, input logic clr);
        client_req_t head;
        bit legal, byp, exp_v, exp_cr, push_ok;
        drive(v, c, d, r, clr);
        @(negedge real_clk);
        legal  = (32'(c) < NUM_CMDS);
        exp_cr = (mq.size() != DEPTH);
        byp    = Bypass && (mq.size() == 0) && v && legal;
        exp_v  = (mq.size() != 0) || byp;
        if (mq.size() != 0)  head = mq[0];
        else if (byp)        head = '{cmd: c, data: d};
        else                 head = '0;
        check("m_valid",  dfcq_valid,   exp_v);
        check("m_offer",  offer,        head.cmd);
        check("m_recv",   receive,      head.data);
        check("m_occ",    occupancy,    mq.size());
        check("m_cready", client_ready, exp_cr);
        check("m_ill",    illegal_cmd,  m_err);
        push_ok = v && exp_cr;
        if (exp_v && r && mq.size() != 0) void'(mq.pop_front());
        if (push_ok && legal && !(byp && r)) mq.push_back('{cmd: c, data: d});
        if (push_ok && !legal) m_err = 1'b1;
        else if (clr)          m_err = 1'b0;
        @(posedge real_clk);
        #1;
    endtask

    initial begin
        ASYNCRESET = 1'b1;
        drive(1'b1, 4'd1, 16'h1111, 1'b0, 1'b0);
        #2;
        check("rst_cready", client_ready, 0);
        check("rst_valid",  dfcq_valid,   0);
        check("rst_occ",    occupancy,    0);
        @(negedge real_clk);
        @(negedge real_clk);
        drive(1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
        ASYNCRESET = 1'b0;
        @(posedge real_clk);
        #1;

`ifndef SRAM_CLIENT_QUEUE_BYPASS_EN
        // Directed vectors: expected outputs seen in the cycle the inputs are applied.
        add(0, 0, 16'h0000, 0, 0,  0, 0, 16'h0000, 0, 1, 0);
        add(1, 1, 16'h00AA, 0, 0,  0, 0, 16'h0000, 0, 1, 0);
        add(0, 0, 16'h0000, 0, 0,  1, 1, 16'h00AA, 1, 1, 0);
        add(1, 2, 16'h0BB0, 0, 0,  1, 1, 16'h00AA, 1, 1, 0);
        add(1, 3, 16'h0CC0, 0, 0,  1, 1, 16'h00AA, 2, 1, 0);
        add(1, 0, 16'h0DD0, 0, 0,  1, 1, 16'h00AA, 3, 1, 0);
        add(1, 1, 16'hEEEE, 0, 0,  1, 1, 16'h00AA, 4, 0, 0);
        add(0, 0, 16'h0000, 1, 0,  1, 1, 16'h00AA, 4, 0, 0);
        add(0, 0, 16'h0000, 1, 0,  1, 2, 16'h0BB0, 3, 1, 0);
        add(0, 0, 16'h0000, 1, 0,  1, 3, 16'h0CC0, 2, 1, 0);
        add(0, 0, 16'h0000, 1, 0,  1, 0, 16'h0DD0, 1, 1, 0);
        add(0, 0, 16'h0000, 1, 0,  0, 0, 16'h0000, 0, 1, 0);
        add(1, 7, 16'h7777, 0, 0,  0, 0, 16'h0000, 0, 1, 0);
        add(0, 0, 16'h0000, 0, 0,  0, 0, 16'h0000, 0, 1, 1);
        add(1, 5, 16'h5555, 0, 1,  0, 0, 16'h0000, 0, 1, 1);
        add(0, 0, 16'h0000, 0, 0,  0, 0, 16'h0000, 0, 1, 1);
        add(0, 0, 16'h0000, 0, 1,  0, 0, 16'h0000, 0, 1, 1);
        add(0, 0, 16'h0000, 0, 0,  0, 0, 16'h0000, 0, 1, 0);
        foreach (vq[i]) begin
            drive(vq[i].valid, vq[i].cmd, vq[i].data, vq[i].ready, vq[i].clr);
            @(negedge real_clk);
            check($sformatf("row%0d valid", i),  dfcq_valid,   vq[i].exp_valid);
            check($sformatf("row%0d offer", i),  offer,        vq[i].exp_offer);
            check($sformatf("row%0d recv", i),   receive,      vq[i].exp_recv);
            check($sformatf("row%0d occ", i),    occupancy,    vq[i].exp_occ);
            check($sformatf("row%0d cready", i), client_ready, vq[i].exp_cready);
            check($sformatf("row%0d ill", i),    illegal_cmd,  vq[i].exp_ill);
            @(posedge real_clk);
            #1;
        end
`else
        // Zero-latency bypass on an empty queue.
        drive(1'b1, 4'd3, 16'h1234, 1'b1, 1'b0);
        #1;
        check("byp_valid", dfcq_valid, 1);
        check("byp_offer", offer,      3);
        check("byp_recv",  receive,    16'h1234);
        check("byp_occ",   occupancy,  0);
        @(posedge real_clk);
        #1;
        drive(1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
        #1;
        check("byp_occ_after",   occupancy,  0);
        check("byp_valid_after", dfcq_valid, 0);
        @(posedge real_clk);
        #1;
`endif

        // Sustained push+pop at occupancy 2 with pointer wrap.
        step(1, 1, 16'hA000, 0, 0);
        step(1, 2, 16'hA001, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 4'(i % 4), 16'hB000 + 16'(i), 1, 0);
        end
        check("steady_occ", mq.size() == 2 ? occupancy : 3'd7, 2);
        step(0, 0, 16'h0, 1, 0);
        step(0, 0, 16'h0, 1, 0);
        step(0, 0, 16'h0, 0, 0);

        // Reset mid-cycle with three entries queued.
        step(1, 1, 16'hC001, 0, 0);
        step(1, 2, 16'hC002, 0, 0);
        step(1, 3, 16'hC003, 0, 0);
        #2;
        drive(1'b1, 4'd1, 16'hBEEF, 1'b1, 1'b0);
        ASYNCRESET = 1'b1;
        #1;
        check("mid_rst_valid",  dfcq_valid,   0);
        check("mid_rst_occ",    occupancy,    0);
        check("mid_rst_cready", client_ready, 0);
        check("mid_rst_offer",  offer,        0);
        check("mid_rst_recv",   receive,      0);
        @(negedge real_clk);
        @(posedge real_clk);
        @(negedge real_clk);
        drive(1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
        ASYNCRESET = 1'b0;
        mq.delete();
        m_err = 1'b0;
        @(posedge real_clk);
        #1;
        step(1, 2, 16'h4242, 0, 0);
        step(0, 0, 16'h0, 1, 0);
        step(0, 0, 16'h0, 0, 0);

        // Randomized traffic; ready probability varies by phase to reach full and empty.
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 150; i++) begin
                logic       v, r, clr;
                logic [3:0] c;
                v   = ($urandom_range(0, 3) != 0);
                c   = ($urandom_range(0, 9) == 0) ? 4'(4 + $urandom_range(0, 11))
                                                  : 4'($urandom_range(0, 3));
                r   = ($urandom_range(0, 3) < p);
                clr = ($urandom_range(0, 15) == 0);
                step(v, c, 16'($urandom), r, clr);
            end
        end
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 16'h0, 1, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
